// File: rtl/pe_pkg.sv
// Shared widths and data type for the systolic PE datapath.
// All arithmetic is unsigned, modulo 2**DATA_W.
package pe_pkg;
  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(256);
  typedef logic [DATA_W-1:0] pe_data_t;
endpackage

// File: rtl/add8.sv
// 8-bit ripple-carry adder; carry-out is dropped so the sum wraps.
module add8
  import pe_pkg::*;
(
  input  pe_data_t a,
  input  pe_data_t b,
  output pe_data_t sum
);
  logic c;

  always_comb begin
    sum = '0;
    c   = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
  end
endmodule

// File: rtl/mul8_lo.sv
// Low 8 bits of a*b from shifted partial products summed
// through a chain of ripple adders.
module mul8_lo
  import pe_pkg::*;
(
  input  pe_data_t a,
  input  pe_data_t b,
  output pe_data_t p
);
  pe_data_t pp [DATA_W];
  pe_data_t s  [DATA_W];

  for (genvar g = 0; g < DATA_W; g++) begin : g_pp
    assign pp[g] = b[g] ? pe_data_t'(a << g) : '0;
  end

  assign s[0] = pp[0];

  for (genvar g = 1; g < DATA_W; g++) begin : g_sum
    add8 u_add (
      .a   (s[g-1]),
      .b   (pp[g]),
      .sum (s[g])
    );
  end

  assign p = s[DATA_W-1];
endmodule

// File: rtl/systolic_pe8.sv
// Systolic PE: forwards operands east/south and accumulates
// K products per dot product through a 2-stage pipeline.
module systolic_pe8
  import pe_pkg::*;
#(
  parameter int K = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  pe_data_t a_in,
  input  pe_data_t b_in,
  input  logic     valid_in,
  input  logic     clear,
  output pe_data_t a_out,
  output pe_data_t b_out,
  output logic     valid_out,
  output pe_data_t result,
  output logic     result_valid
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

  pe_data_t          prod;
  pe_data_t          acc_sum;
  pe_data_t          p_reg;
  pe_data_t          acc;
  logic              p_valid;
  logic [CNT_W-1:0]  count;

  mul8_lo u_mul (
    .a (a_in),
    .b (b_in),
    .p (prod)
  );

  add8 u_acc (
    .a   (acc),
    .b   (p_reg),
    .sum (acc_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out        <= '0;
      b_out        <= '0;
      valid_out    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      p_reg        <= '0;
      p_valid      <= 1'b0;
      acc          <= '0;
      count        <= '0;
    end else begin
      a_out        <= a_in;
      b_out        <= b_in;
      valid_out    <= valid_in;
      result_valid <= 1'b0;
      // clear discards both the new pair and the in-flight product
      if (clear) begin
        p_valid <= 1'b0;
        acc     <= '0;
        count   <= '0;
      end else begin
        p_valid <= valid_in;
        if (valid_in) p_reg <= prod;
        if (p_valid) begin
          if (count == LAST) begin
            result       <= acc_sum;
            result_valid <= 1'b1;
            acc          <= '0;
            count        <= '0;
          end else begin
            acc   <= acc_sum;
            count <= count + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_pe8.sv
// Bench for systolic_pe8: four instances (K=4,2,3,1) share inputs
// and are checked against a dot-product model plus fixed vectors.
module tb_systolic_pe8;
  localparam int N = 4;
  localparam int KS [N] = '{4, 2, 3, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       vin = 1'b0;
  logic [7:0] ain = '0;
  logic [7:0] bin = '0;

  logic [7:0] a_o [N];
  logic [7:0] b_o [N];
  logic [7:0] res [N];
  logic       v_o [N];
  logic       rv  [N];

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    systolic_pe8 #(.K(KS[g])) u_dut (
      .clk          (clk),
      .rst          (rst),
      .a_in         (ain),
      .b_in         (bin),
      .valid_in     (vin),
      .clear        (clear),
      .a_out        (a_o[g]),
      .b_out        (b_o[g]),
      .valid_out    (v_o[g]),
      .result       (res[g]),
      .result_valid (rv[g])
    );
  end

  // reference: pairs accepted into the current dot product,
  // completing two edges after the K-th pair is sampled
  int         m_pend_v [N];
  int         m_pend   [N];
  int         m_sum    [N];
  int         m_n      [N];
  int         m_res    [N];
  int         m_rv     [N];
  logic [7:0] m_a, m_b;
  logic       m_v;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_pend_v[i] = 0; m_pend[i] = 0; m_sum[i] = 0;
      m_n[i] = 0; m_res[i] = 0; m_rv[i] = 0;
    end
    m_a = '0; m_b = '0; m_v = 1'b0;
  end

  always @(posedge clk) begin
    m_a = rst ? 8'd0 : ain;
    m_b = rst ? 8'd0 : bin;
    m_v = rst ? 1'b0 : vin;
    for (int i = 0; i < N; i++) begin
      m_rv[i] = 0;
      if (rst) begin
        m_pend_v[i] = 0; m_sum[i] = 0; m_n[i] = 0; m_res[i] = 0;
      end else if (clear) begin
        m_pend_v[i] = 0; m_sum[i] = 0; m_n[i] = 0;
      end else begin
        if (m_pend_v[i] != 0) begin
          m_sum[i] = (m_sum[i] + m_pend[i]) % 256;
          m_n[i]++;
          if (m_n[i] == KS[i]) begin
            m_res[i] = m_sum[i];
            m_rv[i] = 1;
            m_sum[i] = 0;
            m_n[i] = 0;
          end
        end
        m_pend_v[i] = vin ? 1 : 0;
        m_pend[i] = (int'(ain) * int'(bin)) % 256;
      end
    end
  end

  task automatic drive(input int a, input int b, input logic v, input logic c);
    ain = 8'(a); bin = 8'(b); vin = v; clear = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(9, 9, 1'b1, 1'b0);
    drive(7, 3, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) begin
      n_run++;
      if ({a_o[i], b_o[i], v_o[i], res[i], rv[i]} !== 25'd0) begin
        n_fail++;
        $display("FAIL reset inst%0d: a=%0d b=%0d v=%0b res=%0d rv=%0b, want all 0",
                 i, a_o[i], b_o[i], v_o[i], res[i], rv[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int pa [4] = '{3, 5, 7, 1};
    int pb [4] = '{4, 6, 8, 2};
    int strobes = 0;
    int when = -1;
    int got = -1;
    drive(0, 0, 1'b0, 1'b1);
    for (int s = 0; s < 7; s++) begin
      if (s < 4) drive(pa[s], pb[s], 1'b1, 1'b0);
      else drive(0, 0, 1'b0, 1'b0);
      n_run++;
      if (res[0] !== 8'(m_res[0]) || rv[0] !== m_rv[0][0] ||
          a_o[0] !== m_a || b_o[0] !== m_b || v_o[0] !== m_v) begin
        n_fail++;
        $display("FAIL basic step%0d: res=%0d rv=%0b a=%0d b=%0d v=%0b, want %0d %0d %0d %0d %0b",
                 s, res[0], rv[0], a_o[0], b_o[0], v_o[0], m_res[0], m_rv[0], m_a, m_b, m_v);
      end
      if (rv[0] === 1'b1) begin strobes++; when = s; got = int'(res[0]); end
    end
    n_run++;
    if (strobes != 1 || when != 4 || got != 100) begin
      n_fail++;
      $display("FAIL basic_result: strobes=%0d at=%0d res=%0d, want 1 at 4 res 100",
               strobes, when, got);
    end
  endtask

  task automatic test_wrap();
    int pa [4] = '{15, 10, 16, 200};
    int pb [4] = '{15, 5, 16, 2};
    int got [$];
    drive(0, 0, 1'b0, 1'b1);
    for (int s = 0; s < 6; s++) begin
      if (s < 4) drive(pa[s], pb[s], 1'b1, 1'b0);
      else drive(0, 0, 1'b0, 1'b0);
      n_run++;
      if (rv[1] !== m_rv[1][0] || res[1] !== 8'(m_res[1])) begin
        n_fail++;
        $display("FAIL wrap step%0d: res=%0d rv=%0b, want %0d %0d",
                 s, res[1], rv[1], m_res[1], m_rv[1]);
      end
      if (rv[1] === 1'b1) got.push_back(int'(res[1]));
    end
    n_run++;
    if (got.size() != 2 || got[0] != 19 || got[1] != 144) begin
      n_fail++;
      $display("FAIL wrap_result: n=%0d first=%0d second=%0d, want 2 19 144",
               got.size(), got.size() > 0 ? got[0] : -1, got.size() > 1 ? got[1] : -1);
    end
  endtask

  task automatic test_gaps();
    int pa [4] = '{3, 5, 7, 1};
    int pb [4] = '{4, 6, 8, 2};
    int strobes = 0;
    int got = -1;
    int bad = 0;
    drive(0, 0, 1'b0, 1'b1);
    for (int p = 0; p < 5; p++) begin
      int gap = (p == 4) ? 3 : int'($urandom_range(0, 3));
      if (p < 4) drive(pa[p], pb[p], 1'b1, 1'b0);
      for (int g = 0; g <= gap; g++) begin
        if (g > 0 || p == 4) drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0, 1'b0);
        if (a_o[0] !== m_a || b_o[0] !== m_b || v_o[0] !== m_v ||
            res[0] !== 8'(m_res[0]) || rv[0] !== m_rv[0][0]) bad++;
        if (rv[0] === 1'b1) begin strobes++; got = int'(res[0]); end
      end
    end
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL gaps_track: %0d cycles off from model, want 0", bad);
    end
    n_run++;
    if (strobes != 1 || got != 100) begin
      n_fail++;
      $display("FAIL gaps_result: strobes=%0d res=%0d, want 1 100", strobes, got);
    end
  endtask

  task automatic test_clear();
    int strobes = 0;
    int got = -1;
    int held_bad = 0;
    drive(9, 9, 1'b1, 1'b0);
    drive(2, 2, 1'b1, 1'b0);
    drive(5, 5, 1'b1, 1'b1);
    for (int s = 0; s < 6; s++) begin
      if (s < 4) drive(1, 1, 1'b1, 1'b0);
      else drive(0, 0, 1'b0, 1'b0);
      if (rv[0] === 1'b1) begin strobes++; got = int'(res[0]); end
      else if (strobes == 0 && res[0] !== 8'd100) held_bad++;
    end
    n_run++;
    if (held_bad != 0 || strobes != 1 || got != 4) begin
      n_fail++;
      $display("FAIL clear: held_bad=%0d strobes=%0d res=%0d, want 0 1 4",
               held_bad, strobes, got);
    end
  endtask

  task automatic test_stream();
    int at [$];
    int bad = 0;
    drive(0, 0, 1'b0, 1'b1);
    for (int s = 0; s < 11; s++) begin
      if (s < 9) drive(1, 1, 1'b1, 1'b0);
      else drive(0, 0, 1'b0, 1'b0);
      if (rv[2] === 1'b1) begin
        at.push_back(s);
        if (res[2] !== 8'd3) bad++;
      end
    end
    n_run++;
    if (at.size() != 3 || bad != 0 || at[0] != 3 || at[1] != 6 || at[2] != 9) begin
      n_fail++;
      $display("FAIL stream: strobes=%0d bad_vals=%0d first_at=%0d, want 3 0 3",
               at.size(), bad, at.size() > 0 ? at[0] : -1);
    end
  endtask

  task automatic test_k1();
    int exp_q [$];
    int bad = 0;
    drive(0, 0, 1'b0, 1'b1);
    for (int s = 0; s < 40; s++) begin
      int a = int'($urandom_range(0, 255));
      int b = int'($urandom_range(0, 255));
      logic v = ($urandom_range(0, 3) != 0);
      if (v) exp_q.push_back((a * b) % 256);
      drive(a, b, v, 1'b0);
      if (rv[3] === 1'b1) begin
        if (exp_q.size() == 0 || int'(res[3]) != exp_q.pop_front()) bad++;
      end
    end
    drive(0, 0, 1'b0, 1'b0);
    if (rv[3] === 1'b1 && (exp_q.size() == 0 || int'(res[3]) != exp_q.pop_front())) bad++;
    n_run++;
    if (bad != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL k1: wrong=%0d leftover=%0d, want 0 0", bad, exp_q.size());
    end
  endtask

  task automatic test_random();
    int bad [N] = '{0, 0, 0, 0};
    for (int s = 0; s < 400; s++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 99) < 5);
      for (int i = 0; i < N; i++)
        if (a_o[i] !== m_a || b_o[i] !== m_b || v_o[i] !== m_v ||
            res[i] !== 8'(m_res[i]) || rv[i] !== m_rv[i][0]) bad[i]++;
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_run++;
      if (bad[i] != 0) begin
        n_fail++;
        $display("FAIL random inst%0d K=%0d: %0d cycles off from model, want 0",
                 i, KS[i], bad[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    int got = -1;
    drive(0, 0, 1'b0, 1'b1);
    drive(2, 3, 1'b1, 1'b0);
    drive(2, 3, 1'b1, 1'b0);
    rst = 1'b1;
    drive(2, 3, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_run++;
      if ({a_o[i], b_o[i], v_o[i], res[i], rv[i]} !== 25'd0) begin
        n_fail++;
        $display("FAIL reset_mid inst%0d: a=%0d b=%0d v=%0b res=%0d rv=%0b, want all 0",
                 i, a_o[i], b_o[i], v_o[i], res[i], rv[i]);
      end
    end
    for (int s = 0; s < 6; s++) begin
      if (s < 4) drive(2, 3, 1'b1, 1'b0);
      else drive(0, 0, 1'b0, 1'b0);
      if (rv[0] === 1'b1) begin strobes++; got = int'(res[0]); end
    end
    n_run++;
    if (strobes != 1 || got != 24) begin
      n_fail++;
      $display("FAIL reset_mid_result: strobes=%0d res=%0d, want 1 24", strobes, got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_gaps();
    test_clear();
    test_stream();
    test_k1();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_pe8.md
# systolic_pe8

Processing element for the 8-bit systolic array; consumes the 8-bit adder as its accumulate stage. Each PE forwards operands east/south with a one-cycle register delay and computes a dot product of K operand pairs. For each pair it forms the low 8 bits of `a*b` in a registered multiply stage, then accumulates in a registered add stage. After the K-th valid pair it emits the 8-bit result with a one-cycle strobe and restarts for the next dot product.

## Interface
- `K`, default 4: products per dot product; legal range 1..255.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_in`  in  8  operand from west neighbour.
- `b_in`  in  8  operand from north neighbour.
- `valid_in`  in  1  `a_in`/`b_in` hold a valid pair this cycle.
- `clear`  in  1  synchronous flush of the current dot product.
- `a_out`  out  8  registered `a_in`, to east neighbour.
- `b_out`  out  8  registered `b_in`, to south neighbour.
- `valid_out`  out  1  registered `valid_in`.
- `result`  out  8  last completed dot product.
- `result_valid`  out  1  one-cycle strobe: `result` updated this cycle.

## Operation
- Unsigned arithmetic throughout, modulo 256.
  - Product = `(a*b) mod 256`.
  - Accumulation = `(acc + product) mod 256`.
  - Carry-out is discarded and there is no saturation.
- Forward path:
  - `a_out`, `b_out` and `valid_out` load `a_in`, `b_in` and `valid_in` every cycle.
  - The forward path is unaffected by `clear`; only `rst` affects it.
- Stage 1 (multiply): when `valid_in` is high, `p_reg` loads the product and `p_valid` is set to 1; otherwise `p_valid` is 0.
- Stage 2 (accumulate), taken when `p_valid` is high:
  - If `count < K-1`: `acc` loads `acc + p_reg` and `count` increments.
  - If `count == K-1`: `result` loads `acc + p_reg`, `result_valid` is 1, and `acc` and `count` both return to 0.
- `result_valid` is 0 on every other cycle. `result` holds its value until the next completion.
- `valid_in` may drop for any number of cycles. Gaps stall accumulation and do not reset it.
- `clear` (overrides `valid_in` and `p_valid` in the same cycle):
  - `p_valid`, `acc`, `count` and `result_valid` go to 0, so an in-flight product is discarded.
  - `result` holds its value.
  - A pair presented on the same cycle as `clear` is dropped from the dot product but is still forwarded.
- `rst`: every register goes to 0. This includes `a_out`, `b_out`, `valid_out`, `result`, `result_valid`, `p_reg`, `p_valid`, `acc` and `count`. Reset takes priority over `clear`.
- `K == 1`: every valid pair produces a `result_valid` strobe carrying that pair's product.

## Timing
- Forward latency is 1 cycle: input sampled at edge n appears on `a_out`/`b_out`/`valid_out` after edge n.
- Result latency is 2 cycles: the K-th valid pair, sampled at edge n, gives `result` and `result_valid` = 1 after edge n+1, for that cycle only.
- Throughput is one pair per cycle. Back-to-back dot products need no idle cycle: pair 1 of the next dot product may follow pair K of the previous one on the next cycle.
- Reset mid-operation: all outputs read 0 on the cycle after the `rst` edge. The first valid pair after `rst` deasserts starts a fresh dot product.

## Structure
- Shared package `pe_pkg` holds:
  - `DATA_W = 8`;
  - the count width, `$clog2(256)` = 8 bits;
  - the pe data typedef (8-bit logic vector).
- Sub-module `mul8_lo` is combinational and produces the low 8 bits of the product. It is built from shift-and-add partial products using the existing 8-bit ripple adder.
- Stage 2 instantiates the existing 8-bit adder for `acc + p_reg`.
- Everything else is local registers and the counter, all in `systolic_pe8`.

## Test plan
- K=4, pairs (3,4), (5,6), (7,8), (1,2) on consecutive cycles -> one `result_valid` pulse 2 cycles after the last pair, `result` = 100.
- K=2, pairs (15,15), (10,5) -> `result` = 19 (275 mod 256). Then pair (16,16) -> product 0, and the next pair (200,2) -> `result` = 144.
- K=4 with `valid_in` gaps of 0-3 cycles between the same four pairs as the first scenario -> `result` = 100, with exactly one strobe. `a_out`, `b_out` and `valid_out` track the inputs with 1-cycle delay throughout.
- K=4: two pairs, then `clear` asserted together with a third pair, then four pairs of (1,1) -> `result` = 4, and the previous `result` value holds until that strobe.
- K=3: continuous stream of (1,1) for 9 cycles -> three strobes spaced 3 cycles apart, `result` = 3 each time.
- `rst` asserted mid-dot-product -> all outputs 0 the next cycle; a subsequent full K=4 sequence of (2,3) -> `result` = 24.
